// File: rtl/counter_pkg.sv
// Shared types and control-word layout for the counter / capture slice.
package counter_pkg;

  localparam int unsigned CTRL_WIDTH = 8;
  localparam int unsigned CTRL_EDGE  = 0;
  localparam int unsigned CTRL_CONT  = 1;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StMeasure,
    StHold
  } state_e;

endpackage

// File: rtl/counter_capture_if.sv
// Control/result bundle between the capture block and its register-side consumer.
interface counter_capture_if #(
  parameter int unsigned WIDTH = 8
);

  logic                             enable;
  logic                             signal_in;
  logic [counter_pkg::CTRL_WIDTH-1:0] control;
  logic                             ack;
  logic [WIDTH-1:0]                 period_out;
  logic                             valid;
  logic                             overflow;
  logic                             overrun;

  modport master (
    output enable, signal_in, control, ack,
    input  period_out, valid, overflow, overrun
  );

  modport slave (
    input  enable, signal_in, control, ack,
    output period_out, valid, overflow, overrun
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous pin and emits a one-cycle pulse on the selected edge,
// suppressed for SYNC_STAGES+1 cycles after reset release.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic signal_i,
  input  logic rise_sel_i,
  output logic edge_o
);

  localparam int unsigned MaskCycles = SYNC_STAGES + 1;
  localparam int unsigned MaskW      = $clog2(MaskCycles + 1);
  localparam logic [MaskW-1:0] MaskDone = MaskW'(MaskCycles);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [MaskW-1:0]       mask_q;
  logic                   sync_out;
  logic                   mask_done;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign mask_done = (mask_q == MaskDone);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      mask_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal_i};
      prev_q <= sync_out;
      if (!mask_done) begin
        mask_q <= mask_q + MaskW'(1);
      end
    end
  end

  // Mask hides the false rising edge seen when the pin is already high at reset release.
  assign edge_o = mask_done & (rise_sel_i ? (sync_out & ~prev_q) : (~sync_out & prev_q));

endmodule

// File: rtl/counter_capture.sv
// Input-capture block: measures clk cycles between consecutive selected edges of
// signal_in and reports them over a valid/ack handshake with sticky status.
module counter_capture
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              reset,
  counter_capture_if.slave bus
);

  localparam logic [WIDTH-1:0] CntMax = '1;

  state_e           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] period_q;
  logic             valid_q;
  logic             overflow_q;
  logic             overrun_q;

  logic edge_hit;
  logic capture;
  logic saturate;
  logic unused_ctrl;

  assign unused_ctrl = ^bus.control[CTRL_WIDTH-1:2];

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk       (clk),
    .reset     (reset),
    .signal_i  (bus.signal_in),
    .rise_sel_i(bus.control[CTRL_EDGE]),
    .edge_o    (edge_hit)
  );

  assign capture  = (state_q == StMeasure) && edge_hit;
  assign saturate = (state_q == StMeasure) && !edge_hit && (cnt_q == CntMax);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else if (!bus.enable) begin
      // period_q deliberately retained so software can still read the last result.
      state_q    <= StIdle;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: state_q <= StArmed;
        StArmed: begin
          if (edge_hit) begin
            cnt_q   <= WIDTH'(1);
            state_q <= StMeasure;
          end
        end
        StMeasure: begin
          if (edge_hit) begin
            period_q <= cnt_q;
            if (bus.control[CTRL_CONT]) begin
              cnt_q <= WIDTH'(1);
            end else begin
              state_q <= StHold;
            end
          end else if (cnt_q == CntMax) begin
            cnt_q   <= '0;
            state_q <= StArmed;
          end else begin
            cnt_q <= cnt_q + WIDTH'(1);
          end
        end
        StHold: begin
          if (bus.ack) begin
            state_q <= StArmed;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Set beats clear; a capture coinciding with ack is not an overrun.
      if (capture) begin
        valid_q <= 1'b1;
      end else if (bus.ack) begin
        valid_q <= 1'b0;
      end

      if (capture && valid_q && !bus.ack) begin
        overrun_q <= 1'b1;
      end else if (bus.ack) begin
        overrun_q <= 1'b0;
      end

      if (saturate) begin
        overflow_q <= 1'b1;
      end else if (bus.ack) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign bus.period_out = period_q;
  assign bus.valid      = valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_counter_capture.sv
// Self-checking bench for counter_capture: timestamp-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_counter_capture;
  import counter_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned S     = 2;
  localparam int          MAXC  = (1 << WIDTH) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  counter_capture_if #(.WIDTH(WIDTH)) bus ();

  counter_capture #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(S)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 idle, 1 armed, 2 measuring, 3 holding.
  int               m_mode;
  int               m_start;
  logic [WIDTH-1:0] m_period;
  bit               m_valid, m_ovf, m_ovr;
  logic [31:0]      hist;   // hist[j] = pin value sampled j clocks ago
  int               kclk;   // clocks since reset release
  int               ph;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit qual(bit cur, bit old, bit rise);
    return rise ? (cur && !old) : (!cur && old);
  endfunction

  // Pin changes reach the capture logic a fixed S clocks later.
  function automatic bit edge_next();
    return (kclk + 1 >= int'(S) + 2) && qual(hist[S-1], hist[S], bus.control[CTRL_EDGE]);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_start = 0; m_period = '0;
    m_valid = 0; m_ovf = 0; m_ovr = 0;
    hist = '0; kclk = 0;
  endtask

  task automatic model_step();
    bit e, cap, sat;
    int len;
    hist = {hist[30:0], bus.signal_in};
    if (kclk < 1000000) kclk++;
    e = (kclk >= int'(S) + 2) && qual(hist[S], hist[S+1], bus.control[CTRL_EDGE]);
    if (!bus.enable) begin
      m_mode = 0; m_valid = 0; m_ovf = 0; m_ovr = 0;
    end else begin
      cap = 0; sat = 0;
      case (m_mode)
        0: m_mode = 1;
        1: if (e) begin m_start = kclk; m_mode = 2; end
        2: begin
          len = kclk - m_start;
          if (e) begin
            cap = 1;
            m_period = WIDTH'(len);
            if (bus.control[CTRL_CONT]) m_start = kclk;
            else m_mode = 3;
          end else if (len == MAXC) begin
            sat = 1;
            m_mode = 1;
          end
        end
        default: if (bus.ack) m_mode = 1;
      endcase
      if (cap && m_valid && !bus.ack) m_ovr = 1;
      else if (bus.ack) m_ovr = 0;
      if (sat) m_ovf = 1;
      else if (bus.ack) m_ovf = 0;
      if (cap) m_valid = 1;
      else if (bus.ack) m_valid = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("period_out", 32'(bus.period_out), 32'(m_period));
      chk("valid", 32'(bus.valid), 32'(m_valid));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("overrun", 32'(bus.overrun), 32'(m_ovr));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(int per, int hi, bit ack);
    bus.signal_in = (ph < hi);
    bus.ack       = ack;
    ph            = (ph + 1) % per;
    cyc();
    bus.ack = 1'b0;
  endtask

  task automatic run(int n, int per, int hi, bit auto_ack);
    ph = ph % per;
    for (int i = 0; i < n; i++) tick(per, hi, auto_ack && m_valid);
  endtask

  task automatic rearm(logic [7:0] ctrl);
    bus.enable    = 1'b0;
    bus.signal_in = 1'b0;
    bus.control   = ctrl;
    repeat (6) cyc();
    bus.enable = 1'b1;
    cyc();
    ph = 0;
  endtask

  initial begin
    int guard;
    bus.enable = 1'b0; bus.signal_in = 1'b0; bus.control = 8'h00; bus.ack = 1'b0;
    ph = 0;
    repeat (3) cyc();
    chk("reset_valid", 32'(bus.valid), 32'd0);
    chk("reset_period", 32'(bus.period_out), 32'd0);
    rst_n = 1'b1;

    // Continuous, rising edges every 10 cycles, acked.
    rearm(8'h03);
    run(120, 10, 5, 1'b1);
    chk("cont_period", 32'(bus.period_out), 32'h0A);
    chk("cont_overflow", 32'(bus.overflow), 32'd0);
    chk("cont_overrun", 32'(bus.overrun), 32'd0);

    // Single-shot, falling edges 7 apart, then 12 apart after ack.
    rearm(8'h00);
    run(30, 7, 3, 1'b0);
    repeat (4) cyc();
    chk("ss_period7", 32'(bus.period_out), 32'd7);
    chk("ss_valid_hold", 32'(bus.valid), 32'd1);
    bus.ack = 1'b1; cyc(); bus.ack = 1'b0;
    chk("ss_ack_valid", 32'(bus.valid), 32'd0);
    ph = bus.signal_in ? 0 : 6;
    run(40, 12, 6, 1'b0);
    chk("ss_period12", 32'(bus.period_out), 32'd12);

    // Overflow: one rising edge then a 300-cycle quiet pin.
    rearm(8'h03);
    bus.signal_in = 1'b1;
    repeat (300) cyc();
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    chk("ovf_no_valid", 32'(bus.valid), 32'd0);
    ph = 0;
    run(70, 20, 10, 1'b0);
    chk("ovf_period20", 32'(bus.period_out), 32'd20);
    chk("ovf_still_set", 32'(bus.overflow), 32'd1);
    bus.ack = 1'b1; cyc(); bus.ack = 1'b0;
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);

    // Overrun, then ack landing on a capture with valid already high.
    rearm(8'h03);
    run(30, 5, 2, 1'b0);
    chk("ovr_set", 32'(bus.overrun), 32'd1);
    chk("ovr_period5", 32'(bus.period_out), 32'd5);
    guard = 0;
    while (edge_next() && guard < 50) begin tick(5, 2, 1'b0); guard++; end
    tick(5, 2, 1'b1);
    chk("ovr_cleared", 32'(bus.overrun), 32'd0);
    guard = 0;
    while (!m_valid && guard < 50) begin tick(5, 2, 1'b0); guard++; end
    while (!(edge_next() && m_mode == 2) && guard < 100) begin tick(5, 2, 1'b0); guard++; end
    chk("wait_capture_in_budget", 32'(guard < 100), 32'd1);
    tick(5, 2, 1'b1);
    chk("same_cycle_valid", 32'(bus.valid), 32'd1);
    chk("same_cycle_overrun", 32'(bus.overrun), 32'd0);
    chk("same_cycle_period", 32'(bus.period_out), 32'd5);

    // Reset released with pin already high: startup mask swallows the false edge.
    rst_n = 1'b0;
    bus.signal_in = 1'b1; bus.enable = 1'b1; bus.control = 8'h03;
    cyc(); cyc();
    rst_n = 1'b1;
    repeat (20) cyc();
    chk("mask_no_capture", 32'(bus.valid), 32'd0);

    // enable dropped mid-measure.
    ph = 0;
    run(30, 5, 2, 1'b0);
    bus.enable = 1'b0;
    cyc();
    chk("en_drop_valid", 32'(bus.valid), 32'd0);
    chk("en_drop_ovr", 32'(bus.overrun), 32'd0);
    chk("en_drop_period", 32'(bus.period_out), 32'd5);
    cyc(); cyc();
    bus.enable = 1'b1;
    run(25, 5, 2, 1'b0);

    // Async reset mid-count, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("async_period", 32'(bus.period_out), 32'd0);
    chk("async_valid", 32'(bus.valid), 32'd0);
    chk("async_ovr", 32'(bus.overrun), 32'd0);
    cyc();
    rst_n = 1'b1;

    // Randomised traffic.
    begin
      int hold = 1;
      bus.enable = 1'b1;
      for (int i = 0; i < 6000; i++) begin
        if (--hold == 0) begin
          bus.signal_in = ~bus.signal_in;
          hold = ($urandom_range(0, 19) == 0) ? int'($urandom_range(200, 300))
                                              : int'($urandom_range(1, 30));
        end
        if ($urandom_range(0, 299) == 0) bus.control = 8'($urandom);
        bus.enable = ($urandom_range(0, 199) != 0);
        bus.ack    = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end
      bus.ack = 1'b0;
    end

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_capture.md
Name: counter_capture

Overview:
Input-capture block that is the measuring counterpart of the counter. The counter generates events at a programmed period; this block receives an external pulse train and reports the number of clk cycles between consecutive selected edges. Results go to the register/control side through a valid/ack handshake, with sticky overflow and overrun status.

Parameters:
WIDTH, 8, width of the internal cycle counter and period_out. Maximum measurable period is 2^WIDTH-1 cycles.
SYNC_STAGES, 2, number of synchroniser flops on signal_in. Minimum is 2.

Ports:
clk  input  1  system clock; all flops on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
enable  input  1  1 = capture active; 0 = idle and clear status
signal_in  input  1  asynchronous pulse train to measure
control  input  8  [0] edge select (1 = rising, 0 = falling); [1] mode (1 = continuous, 0 = single-shot); [7:2] reserved, ignored
ack  input  1  consumer acknowledges current result
period_out  output  WIDTH  last captured period in clk cycles
valid  output  1  period_out holds an unacknowledged result
overflow  output  1  sticky: counter saturated before the next edge
overrun  output  1  sticky: a new result overwrote an unacknowledged one

Behaviour:
- Reset (async assert, sync deassert): all outputs 0; counter 0; synchroniser flops 0; state IDLE.
- Edge detection: SYNC_STAGES-flop synchroniser, then a previous-sample flop. An edge is qualified when (sync, prev) = (1,0) for control[0]=1, or (0,1) for control[0]=0. Fixed latency from pin change to qualified edge: SYNC_STAGES+1 cycles. The latency is constant, so measured periods are exact.
- Startup mask: qualified edges are ignored for SYNC_STAGES+1 cycles after reset release. This suppresses the spurious edge caused by flops resetting to 0 while signal_in is already high.
- States:
  - IDLE: when enable=1, go to ARMED next cycle.
  - ARMED: on a qualified edge, cnt<=1 and go to MEASURE.
  - MEASURE: cnt increments each cycle. On a qualified edge, period_out<=cnt and valid<=1. Then either cnt<=1 and stay in MEASURE (continuous), or go to HOLD (single-shot).
  - HOLD: edges ignored. On ack=1, valid<=0 and go to ARMED.
- Result: edges N cycles apart give period_out = N.
- Saturation: in MEASURE, if cnt = 2^WIDTH-1 and no edge arrives this cycle, set overflow=1, cnt<=0, go to ARMED. No result is produced.
- An edge in the same cycle as cnt = max is a valid capture of max. It does not set overflow.
- Handshake:
  - valid stays high until ack=1 is sampled.
  - ack while valid=0 has no effect, apart from clearing sticky flags.
  - Capture and ack in the same cycle: the capture wins, valid stays 1, period_out takes the new value, and overrun is not set.
  - Capture while valid=1 and no ack: period_out is overwritten, valid stays 1, overrun<=1.
- Sticky flags: overflow and overrun clear on ack=1 (when not set in the same cycle) or when enable=0. Set has priority over clear.
- enable=0 from any state: next cycle state is IDLE, cnt=0, valid=0, flags 0. period_out is retained. The synchroniser keeps running.
- control may change at any time. It is used combinationally. Changing control[0] mid-measure can cause a false edge; software re-arms by toggling enable.
- Reset mid-operation: immediate return to reset values, and the startup mask restarts.

Decomposition:
- counter_pkg:
  - state enum (IDLE, ARMED, MEASURE, HOLD)
  - control bit indices CTRL_EDGE=0, CTRL_CONT=1
  - CTRL_WIDTH=8
- Sub-module sync_edge_detect: synchroniser, previous-sample flop, polarity select and startup mask. Outputs a one-cycle edge pulse.
- counter_capture holds the FSM, counter, result register and status flags.

Test Plan:
- Continuous mode: control=8'h03, WIDTH=8, rising edges every 10 cycles, ack pulsed after each valid. Each result is period_out=8'h0A with overflow=0 and overrun=0.
- Single-shot, falling edges: control=8'h00, falling edges 7 cycles apart, no ack for 30 cycles. period_out=7 and valid=1 hold; later edges are ignored. After ack, valid=0, and the next pair of edges 12 apart gives period_out=12.
- Overflow: control=8'h03, one rising edge then none for 300 cycles. overflow=1 at 255 cycles after the edge and valid stays 0. Edges then 20 apart give period_out=20 with overflow still 1, which clears on ack.
- Overrun and same-cycle case: edges every 5 cycles, no ack. Second capture sets overrun=1 with period_out=5. Ack in the same cycle as a capture leaves valid=1 and overrun unchanged.
- Reset/enable corners: reset released with signal_in=1 and enable=1 gives no capture during the mask. enable dropped mid-MEASURE for 3 cycles gives valid=0 and flags 0 next cycle, with period_out retained. Async reset asserted mid-count zeroes all outputs with no clock edge.
